// File: rtl/pd_pwr_pkg.sv
// Shared types and constants for the PD1 power-state controller.
package pd_pwr_pkg;

  typedef enum logic [3:0] {
    ST_ON        = 4'd0,
    ST_SLP_REQ   = 4'd1,
    ST_CLK_OFF   = 4'd2,
    ST_ISO_ON    = 4'd3,
    ST_RET_ON    = 4'd4,
    ST_RST_ON    = 4'd5,
    ST_PWR_OFF   = 4'd6,
    ST_OFF       = 4'd7,
    ST_PWR_ON    = 4'd8,
    ST_RST_REL   = 4'd9,
    ST_RET_OFF   = 4'd10,
    ST_ISO_OFF   = 4'd11,
    ST_CLK_ON    = 4'd12,
    ST_RST_ON_CG = 4'd13,
    ST_CG_OFF    = 4'd14
  } state_e;

  // Output values with the domain fully on.
  localparam state_e RST_STATE      = ST_ON;
  localparam logic   RST_SLEEP_REQ  = 1'b0;
  localparam logic   RST_CLK_EN     = 1'b1;
  localparam logic   RST_ISO        = 1'b0;
  localparam logic   RST_RET        = 1'b0;
  localparam logic   RST_RSTN       = 1'b1;
  localparam logic   RST_PWR_ON_REQ = 1'b1;
  localparam logic   RST_PD_OFF     = 1'b0;
  localparam logic   RST_BUSY       = 1'b0;

  // Stable states are ON and the two sleep states; everything else is in flight.
  function automatic logic is_busy(state_e s);
    return !((s == ST_ON) || (s == ST_OFF) || (s == ST_CG_OFF));
  endfunction

  // Power-down steps during which a wake-up is remembered rather than acted on.
  function automatic logic is_wake_latch_state(state_e s);
    return (s inside {ST_CLK_OFF, ST_ISO_ON, ST_RET_ON, ST_RST_ON,
                      ST_PWR_OFF, ST_RST_ON_CG});
  endfunction

endpackage

// File: rtl/pd_step_timer.sv
// Step timer: loads (delay-1) with 0 treated as 1, counts down, flags zero.
module pd_step_timer #(
  parameter int DLY_W = 4
) (
  input  logic             i_aon_clk,
  input  logic             i_soc_pwr_on_rst,
  input  logic             i_load,
  input  logic [DLY_W-1:0] i_load_val,
  output logic             o_done
);

  localparam logic [DLY_W-1:0] ONE = DLY_W'(1);

  logic [DLY_W-1:0] r_cnt;
  logic [DLY_W-1:0] w_eff_dly;

  assign w_eff_dly = (i_load_val == '0) ? ONE : i_load_val;

  // Countdown register: reload on step entry, otherwise decrement to zero and hold.
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_eff_dly - ONE;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  // A timed step ends in the cycle the count reads zero.
  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/pd1_pwr_seq_ctrl.sv
// Always-on power-state controller for PD1: sleep handshake and
// clock/isolation/retention/reset/power-switch sequencing.
module pd1_pwr_seq_ctrl
  import pd_pwr_pkg::*;
#(
  parameter int DLY_W = 4
) (
  input  logic             i_aon_clk,
  input  logic             i_soc_pwr_on_rst,
  input  logic             i_sw_sleep_req,
  input  logic             i_wakeup_evt,
  input  logic             i_pg_en,
  input  logic             i_ret_en,
  input  logic [DLY_W-1:0] i_pwr_off_seq_delay,
  input  logic [DLY_W-1:0] i_pwr_on_seq_delay,
  input  logic             i_hw_sleep_ack,
  input  logic             i_pwr_on_ack,
  output logic             o_sleep_req,
  output logic             o_clk_en,
  output logic             o_iso,
  output logic             o_ret,
  output logic             o_rstn,
  output logic             o_pwr_on_req,
  output logic             o_pd_off,
  output logic             o_busy,
  output logic [3:0]       o_state
);

  state_e           r_state, w_state_next;
  logic             r_sleep_req, w_sleep_req_next;
  logic             r_clk_en, w_clk_en_next;
  logic             r_iso, w_iso_next;
  logic             r_ret, w_ret_next;
  logic             r_rstn, w_rstn_next;
  logic             r_pwr_on_req, w_pwr_on_req_next;
  logic             r_pd_off, w_pd_off_next;
  logic             r_busy, w_busy_next;
  logic             r_wake_pend, w_wake_pend_next;
  logic [DLY_W-1:0] r_d_off, w_d_off_next;
  logic [DLY_W-1:0] r_d_on, w_d_on_next;
  logic             w_load;
  logic [DLY_W-1:0] w_load_val;
  logic             w_done;
  logic             w_wake;

  pd_step_timer #(.DLY_W(DLY_W)) u_step_timer (
    .i_aon_clk        (i_aon_clk),
    .i_soc_pwr_on_rst (i_soc_pwr_on_rst),
    .i_load           (w_load),
    .i_load_val       (w_load_val),
    .o_done           (w_done)
  );

  assign w_wake = i_wakeup_evt | r_wake_pend;

  // Next state and next output levels; outputs only change on state entry.
  always_comb begin
    w_state_next      = r_state;
    w_sleep_req_next  = r_sleep_req;
    w_clk_en_next     = r_clk_en;
    w_iso_next        = r_iso;
    w_ret_next        = r_ret;
    w_rstn_next       = r_rstn;
    w_pwr_on_req_next = r_pwr_on_req;
    w_pd_off_next     = r_pd_off;
    w_d_off_next      = r_d_off;
    w_d_on_next       = r_d_on;
    w_load            = 1'b0;
    w_load_val        = r_d_off;
    // A wake-up during power-down is held until the domain reaches OFF/CG_OFF.
    w_wake_pend_next  = r_wake_pend | (i_wakeup_evt & is_wake_latch_state(r_state));

    case (r_state)
      ST_ON: begin
        if (i_sw_sleep_req && !i_wakeup_evt) begin
          w_state_next     = ST_SLP_REQ;
          w_sleep_req_next = 1'b1;
          w_d_off_next     = i_pwr_off_seq_delay;
          w_d_on_next      = i_pwr_on_seq_delay;
        end
      end
      ST_SLP_REQ: begin
        // Abort wins over a simultaneous acknowledge.
        if (i_wakeup_evt || !i_sw_sleep_req) begin
          w_state_next     = ST_ON;
          w_sleep_req_next = 1'b0;
        end else if (i_hw_sleep_ack) begin
          w_state_next  = ST_CLK_OFF;
          w_clk_en_next = 1'b0;
          w_load        = 1'b1;
        end
      end
      ST_CLK_OFF: begin
        if (w_done) begin
          w_load = 1'b1;
          if (i_pg_en) begin
            w_state_next = ST_ISO_ON;
            w_iso_next   = 1'b1;
          end else begin
            w_state_next = ST_RST_ON_CG;
            w_rstn_next  = 1'b0;
          end
        end
      end
      ST_ISO_ON: begin
        if (w_done) begin
          w_state_next = ST_RET_ON;
          w_ret_next   = i_ret_en;
          w_load       = 1'b1;
        end
      end
      ST_RET_ON: begin
        if (w_done) begin
          w_state_next = ST_RST_ON;
          w_rstn_next  = 1'b0;
          w_load       = 1'b1;
        end
      end
      ST_RST_ON: begin
        if (w_done) begin
          w_state_next      = ST_PWR_OFF;
          w_pwr_on_req_next = 1'b0;
        end
      end
      ST_PWR_OFF: begin
        if (!i_pwr_on_ack) begin
          w_state_next  = ST_OFF;
          w_pd_off_next = 1'b1;
        end
      end
      ST_RST_ON_CG: begin
        if (w_done) begin
          w_state_next  = ST_CG_OFF;
          w_pd_off_next = 1'b1;
        end
      end
      ST_OFF: begin
        if (w_wake) begin
          w_state_next      = ST_PWR_ON;
          w_pwr_on_req_next = 1'b1;
          w_pd_off_next     = 1'b0;
          w_d_on_next       = i_pwr_on_seq_delay;
          w_wake_pend_next  = 1'b0;
        end
      end
      ST_CG_OFF: begin
        // Clock-gated sleep never dropped power, so go straight to reset release.
        if (w_wake) begin
          w_state_next     = ST_RST_REL;
          w_rstn_next      = 1'b1;
          w_pd_off_next    = 1'b0;
          w_d_on_next      = i_pwr_on_seq_delay;
          w_wake_pend_next = 1'b0;
          w_load           = 1'b1;
          w_load_val       = i_pwr_on_seq_delay;
        end
      end
      ST_PWR_ON: begin
        if (i_pwr_on_ack) begin
          w_state_next     = ST_RST_REL;
          w_rstn_next      = 1'b1;
          w_wake_pend_next = 1'b0;
          w_load           = 1'b1;
          w_load_val       = r_d_on;
        end
      end
      ST_RST_REL: begin
        if (w_done) begin
          w_state_next = ST_RET_OFF;
          w_ret_next   = 1'b0;
          w_load       = 1'b1;
          w_load_val   = r_d_on;
        end
      end
      ST_RET_OFF: begin
        if (w_done) begin
          w_state_next = ST_ISO_OFF;
          w_iso_next   = 1'b0;
          w_load       = 1'b1;
          w_load_val   = r_d_on;
        end
      end
      ST_ISO_OFF: begin
        if (w_done) begin
          w_state_next  = ST_CLK_ON;
          w_clk_en_next = 1'b1;
          w_load        = 1'b1;
          w_load_val    = r_d_on;
        end
      end
      ST_CLK_ON: begin
        if (w_done) begin
          w_state_next     = ST_ON;
          w_sleep_req_next = 1'b0;
        end
      end
      default: begin
        // Unused encoding: recover to the fully-on configuration.
        w_state_next      = RST_STATE;
        w_sleep_req_next  = RST_SLEEP_REQ;
        w_clk_en_next     = RST_CLK_EN;
        w_iso_next        = RST_ISO;
        w_ret_next        = RST_RET;
        w_rstn_next       = RST_RSTN;
        w_pwr_on_req_next = RST_PWR_ON_REQ;
        w_pd_off_next     = RST_PD_OFF;
        w_wake_pend_next  = 1'b0;
      end
    endcase

    w_busy_next = is_busy(w_state_next);
  end

  // State, output and latched-delay registers; reset forces the domain fully on at once.
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) begin
      r_state      <= RST_STATE;
      r_sleep_req  <= RST_SLEEP_REQ;
      r_clk_en     <= RST_CLK_EN;
      r_iso        <= RST_ISO;
      r_ret        <= RST_RET;
      r_rstn       <= RST_RSTN;
      r_pwr_on_req <= RST_PWR_ON_REQ;
      r_pd_off     <= RST_PD_OFF;
      r_busy       <= RST_BUSY;
      r_wake_pend  <= 1'b0;
      r_d_off      <= '0;
      r_d_on       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_sleep_req  <= w_sleep_req_next;
      r_clk_en     <= w_clk_en_next;
      r_iso        <= w_iso_next;
      r_ret        <= w_ret_next;
      r_rstn       <= w_rstn_next;
      r_pwr_on_req <= w_pwr_on_req_next;
      r_pd_off     <= w_pd_off_next;
      r_busy       <= w_busy_next;
      r_wake_pend  <= w_wake_pend_next;
      r_d_off      <= w_d_off_next;
      r_d_on       <= w_d_on_next;
    end
  end

  assign o_sleep_req  = r_sleep_req;
  assign o_clk_en     = r_clk_en;
  assign o_iso        = r_iso;
  assign o_ret        = r_ret;
  assign o_rstn       = r_rstn;
  assign o_pwr_on_req = r_pwr_on_req;
  assign o_pd_off     = r_pd_off;
  assign o_busy       = r_busy;
  assign o_state      = r_state;

endmodule

// File: tb/tb_pd1_pwr_seq_ctrl.sv
// Bench for pd1_pwr_seq_ctrl: directed sequences plus random stimulus, every
// cycle checked against a step-list reference model of the power sequencing.
module tb_pd1_pwr_seq_ctrl;

  localparam int DW = 4;

  localparam int S_ON = 0, S_SLP_REQ = 1, S_CLK_OFF = 2, S_ISO_ON = 3,
                 S_RET_ON = 4, S_RST_ON = 5, S_PWR_OFF = 6, S_OFF = 7,
                 S_PWR_ON = 8, S_RST_REL = 9, S_RET_OFF = 10, S_ISO_OFF = 11,
                 S_CLK_ON = 12, S_RST_ON_CG = 13, S_CG_OFF = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          sleep_req_in, wakeup, pg_en, ret_en, hw_ack, pwr_ack;
  logic [DW-1:0] doff, don;
  logic          o_sleep_req, o_clk_en, o_iso, o_ret, o_rstn, o_pwr_on_req;
  logic          o_pd_off, o_busy;
  logic [3:0]    o_state;

  always #5 clk = ~clk;

  pd1_pwr_seq_ctrl #(.DLY_W(DW)) dut (
    .i_aon_clk           (clk),
    .i_soc_pwr_on_rst    (rst),
    .i_sw_sleep_req      (sleep_req_in),
    .i_wakeup_evt        (wakeup),
    .i_pg_en             (pg_en),
    .i_ret_en            (ret_en),
    .i_pwr_off_seq_delay (doff),
    .i_pwr_on_seq_delay  (don),
    .i_hw_sleep_ack      (hw_ack),
    .i_pwr_on_ack        (pwr_ack),
    .o_sleep_req         (o_sleep_req),
    .o_clk_en            (o_clk_en),
    .o_iso               (o_iso),
    .o_ret               (o_ret),
    .o_rstn              (o_rstn),
    .o_pwr_on_req        (o_pwr_on_req),
    .o_pd_off            (o_pd_off),
    .o_busy              (o_busy),
    .o_state             (o_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: current step, cycles left in it, latched delays and flags.
  int m_state, m_rem, m_doff, m_don;
  bit m_pend, m_ret, m_pg;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    m_state = S_ON;
    m_rem   = 0;
    m_pend  = 1'b0;
    m_ret   = 1'b0;
    m_pg    = 1'b0;
  endtask

  // One clock of the reference: a timed step lasts exactly its delay in cycles.
  task automatic model_step();
    int nxt;
    bit set_pend;
    set_pend = wakeup && (m_state inside {S_CLK_OFF, S_ISO_ON, S_RET_ON, S_RST_ON,
                                          S_PWR_OFF, S_RST_ON_CG});
    nxt = m_state;
    if (m_rem > 0) m_rem--;
    case (m_state)
      S_ON:        if (sleep_req_in && !wakeup) begin
                     nxt = S_SLP_REQ; m_doff = eff(int'(doff)); m_don = eff(int'(don));
                   end
      S_SLP_REQ:   if (wakeup || !sleep_req_in) nxt = S_ON;
                   else if (hw_ack) begin nxt = S_CLK_OFF; m_rem = m_doff; end
      S_CLK_OFF:   if (m_rem == 0) begin
                     m_pg = pg_en; nxt = pg_en ? S_ISO_ON : S_RST_ON_CG; m_rem = m_doff;
                   end
      S_ISO_ON:    if (m_rem == 0) begin nxt = S_RET_ON; m_ret = ret_en; m_rem = m_doff; end
      S_RET_ON:    if (m_rem == 0) begin nxt = S_RST_ON; m_rem = m_doff; end
      S_RST_ON:    if (m_rem == 0) nxt = S_PWR_OFF;
      S_RST_ON_CG: if (m_rem == 0) nxt = S_CG_OFF;
      S_PWR_OFF:   if (!pwr_ack) nxt = S_OFF;
      S_OFF:       if (wakeup || m_pend) begin nxt = S_PWR_ON; m_don = eff(int'(don)); end
      S_CG_OFF:    if (wakeup || m_pend) begin
                     nxt = S_RST_REL; m_don = eff(int'(don)); m_rem = m_don;
                   end
      S_PWR_ON:    if (pwr_ack) begin nxt = S_RST_REL; m_rem = m_don; end
      S_RST_REL:   if (m_rem == 0) begin nxt = S_RET_OFF; m_rem = m_don; end
      S_RET_OFF:   if (m_rem == 0) begin nxt = S_ISO_OFF; m_rem = m_don; end
      S_ISO_OFF:   if (m_rem == 0) begin nxt = S_CLK_ON; m_rem = m_don; end
      S_CLK_ON:    if (m_rem == 0) nxt = S_ON;
      default:     nxt = S_ON;
    endcase
    m_pend = m_pend | set_pend;
    if ((nxt != m_state) && (nxt == S_PWR_ON || nxt == S_RST_REL)) m_pend = 1'b0;
    m_state = nxt;
  endtask

  // Expected outputs decoded from the position in the sequence.
  task automatic check_all();
    bit e_iso, e_ret;
    e_iso = m_pg && (m_state inside {S_ISO_ON, S_RET_ON, S_RST_ON, S_PWR_OFF, S_OFF,
                                     S_PWR_ON, S_RST_REL, S_RET_OFF});
    e_ret = m_pg && m_ret && (m_state inside {S_RET_ON, S_RST_ON, S_PWR_OFF, S_OFF,
                                              S_PWR_ON, S_RST_REL});
    check_val("state",      32'(o_state),      32'(m_state));
    check_val("sleep_req",  32'(o_sleep_req),  32'(m_state != S_ON));
    check_val("clk_en",     32'(o_clk_en),     32'(m_state inside {S_ON, S_SLP_REQ, S_CLK_ON}));
    check_val("iso",        32'(o_iso),        32'(e_iso));
    check_val("ret",        32'(o_ret),        32'(e_ret));
    check_val("rstn",       32'(o_rstn),       32'(!(m_state inside {S_RST_ON, S_PWR_OFF, S_OFF,
                                                    S_PWR_ON, S_RST_ON_CG, S_CG_OFF})));
    check_val("pwr_on_req", 32'(o_pwr_on_req), 32'(!(m_state inside {S_PWR_OFF, S_OFF})));
    check_val("pd_off",     32'(o_pd_off),     32'(m_state inside {S_OFF, S_CG_OFF}));
    check_val("busy",       32'(o_busy),       32'(!(m_state inside {S_ON, S_OFF, S_CG_OFF})));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset: outputs must reach reset values before any clock edge.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    sleep_req_in = 1'b0; wakeup = 1'b0; pg_en = 1'b1; ret_en = 1'b1;
    hw_ack = 1'b0; pwr_ack = 1'b1; doff = 4'd3; don = 4'd2;
    model_reset();
    m_doff = 1; m_don = 1;
    pulse_reset();
    run(2);

    // Full power gating, off delay 3, on delay 2.
    sleep_req_in = 1'b1; run(2);
    hw_ack = 1'b1; run(1);
    hw_ack = 1'b0; sleep_req_in = 1'b0; run(14);
    pwr_ack = 1'b0; run(3);
    wakeup = 1'b1; run(1);
    wakeup = 1'b0; run(2);
    pwr_ack = 1'b1; run(12);

    // Clock-gated sleep with zero delays.
    pg_en = 1'b0; doff = 4'd0; don = 4'd0;
    sleep_req_in = 1'b1; hw_ack = 1'b1; run(2);
    sleep_req_in = 1'b0; hw_ack = 1'b0; run(5);
    wakeup = 1'b1; run(1);
    wakeup = 1'b0; run(8);

    // Abort before acknowledge.
    pg_en = 1'b1; doff = 4'd2; don = 4'd1;
    sleep_req_in = 1'b1; run(2);
    wakeup = 1'b1; run(1);
    wakeup = 1'b0; sleep_req_in = 1'b0; run(3);

    // Wake-up arriving during ISO_ON completes the power-down first.
    sleep_req_in = 1'b1; hw_ack = 1'b1; run(2);
    sleep_req_in = 1'b0; hw_ack = 1'b0; run(2);
    wakeup = 1'b1; run(1);
    wakeup = 1'b0; run(6);
    pwr_ack = 1'b0; run(3);
    pwr_ack = 1'b1; run(10);

    // Reset while in RET_ON.
    doff = 4'd3; sleep_req_in = 1'b1; hw_ack = 1'b1; run(9);
    check_val("pre_rst_state", 32'(o_state), 32'(S_RET_ON));
    sleep_req_in = 1'b0; hw_ack = 1'b0;
    pulse_reset();
    run(2);

    // Retention disabled with the longest delays.
    ret_en = 1'b0; doff = 4'd15; don = 4'd15;
    sleep_req_in = 1'b1; hw_ack = 1'b1; run(2);
    sleep_req_in = 1'b0; hw_ack = 1'b0; run(50);
    pwr_ack = 1'b0; run(2);
    wakeup = 1'b1; pwr_ack = 1'b1; run(1);
    wakeup = 1'b0; run(65);

    // Random stimulus.
    for (int i = 0; i < 4000; i++) begin
      sleep_req_in = ($urandom_range(0, 9) < 8);
      wakeup       = ($urandom_range(0, 29) == 0);
      hw_ack       = ($urandom_range(0, 2) == 0);
      pwr_ack      = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 49) == 0) pg_en  = $urandom_range(0, 1);
      if ($urandom_range(0, 49) == 0) ret_en = $urandom_range(0, 1);
      if ($urandom_range(0, 39) == 0)
        doff = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0)
        don  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom_range(0, 3));
      if ($urandom_range(0, 599) == 0) pulse_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
